// File: rtl/nr_divider_pipe.sv
// nr_divider_pipe: handshaked unsigned divider built on Newton-Raphson reciprocal refinement.
// Define NR_DIVIDER_EXACT_EN to add the REM/CORR stages that make quotient/remainder exact.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// NORM  | zero-divisor check, divisor normalisation, reciprocal seed
// ITER  | Newton-Raphson refinement, two cycles per iteration
// QMUL  | quotient estimate (or zero-divisor result) loaded
// REM   | signed remainder of the estimate
// CORR  | one +/-1 quotient fix per cycle
// DONE  | result held until out_ready
module nr_divider_pipe #(
   parameter int WIDTH = 16,
   parameter int ITERS = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] numerator,
   input  logic [WIDTH-1:0] denominator,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int FRAC = WIDTH + 2;
   localparam int XW   = FRAC + 2;
   localparam int PW   = WIDTH + XW;
   localparam int SW   = $clog2(WIDTH + 1);
   localparam int SHW  = $clog2(FRAC + WIDTH + 1);
   localparam int IW   = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam int RW   = WIDTH + 2;

   // 2.9142 and 2.0 as fixed-point values with FRAC fraction bits
   localparam logic [XW-1:0] SEED = XW'(((64'd29142 << FRAC) + 64'd5000) / 64'd10000);
   localparam logic [XW-1:0] TWO  = XW'(64'd2 << FRAC);

   typedef enum logic [2:0] {
      S_IDLE, S_NORM, S_ITER, S_QMUL, S_REM, S_CORR, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] num_q, num_d;
   logic [WIDTH-1:0] den_q, den_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [FRAC-1:0]  dn_q, dn_d;
   logic [SW-1:0]    s_q, s_d;
   logic [XW-1:0]    x_q, x_d;
   logic [XW-1:0]    t_q, t_d;
   logic             ph_q, ph_d;
   logic             dz_q, dz_d;
   logic [IW-1:0]    it_q, it_d;

   logic [SW-1:0]    lz;
   logic [WIDTH-1:0] den_norm;
   logic [XW-1:0]    t_next;
   logic [XW-1:0]    two_m_t;
   logic [XW-1:0]    x_next;
   logic [SHW-1:0]   q_sh;
   logic [PW-1:0]    q_shift;
   logic [WIDTH-1:0] q_est;

   function automatic logic [SW-1:0] lzc(input logic [WIDTH-1:0] v);
      logic [SW-1:0] n;
      logic          found;
      n     = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + SW'(1);
         end
      end
      return n;
   endfunction

   assign lz       = lzc(den_q);
   assign den_norm = den_q << lz;
   assign t_next   = XW'(({{XW{1'b0}}, dn_q} * {{FRAC{1'b0}}, x_q}) >> FRAC);
   assign two_m_t  = TWO - t_q;
   assign x_next   = XW'(({{XW{1'b0}}, x_q} * {{XW{1'b0}}, two_m_t}) >> FRAC);
   assign q_sh     = SHW'(FRAC + WIDTH) - SHW'(s_q);
   assign q_shift  = ({{XW{1'b0}}, num_q} * {{WIDTH{1'b0}}, x_q}) >> q_sh;
   assign q_est    = (|q_shift[PW-1:WIDTH]) ? '1 : q_shift[WIDTH-1:0];

`ifdef NR_DIVIDER_EXACT_EN
   logic signed [RW-1:0] r_q, r_d;
   logic signed [RW-1:0] den_s;
   logic signed [RW-1:0] r_calc;
   logic signed [RW-1:0] r_adj;

   function automatic logic in_range(input logic signed [RW-1:0] r,
                                     input logic signed [RW-1:0] d);
      return !r[RW-1] && (r < d);
   endfunction

   assign den_s  = $signed({2'b00, den_q});
   assign r_calc = $signed({2'b00, num_q})
                   - $signed(RW'({{WIDTH{1'b0}}, q_q} * {{WIDTH{1'b0}}, den_q}));
   assign r_adj  = r_q[RW-1] ? (r_q + den_s) : (r_q - den_s);
`endif

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      den_d   = den_q;
      q_d     = q_q;
      dn_d    = dn_q;
      s_d     = s_q;
      x_d     = x_q;
      t_d     = t_q;
      ph_d    = ph_q;
      dz_d    = dz_q;
      it_d    = it_q;
`ifdef NR_DIVIDER_EXACT_EN
      r_d     = r_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               num_d   = numerator;
               den_d   = denominator;
               dz_d    = 1'b0;
               ph_d    = 1'b0;
               it_d    = '0;
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            // zero divisor result is loaded in QMUL so the result registers have a single load point
            if (den_q == '0) begin
               dz_d    = 1'b1;
               state_d = S_QMUL;
            end else begin
               s_d     = lz;
               dn_d    = {den_norm, 2'b00};
               x_d     = SEED - {1'b0, den_norm, 2'b00, 1'b0};
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            if (!ph_q) begin
               t_d  = t_next;
               ph_d = 1'b1;
            end else begin
               x_d  = x_next;
               ph_d = 1'b0;
               if (it_q == IW'(ITERS - 1)) begin
                  it_d    = '0;
                  state_d = S_QMUL;
               end else begin
                  it_d = it_q + IW'(1);
               end
            end
         end
         S_QMUL: begin
            if (dz_q) begin
               q_d     = '1;
`ifdef NR_DIVIDER_EXACT_EN
               r_d     = $signed({2'b00, num_q});
`endif
               state_d = S_DONE;
            end else begin
               q_d     = q_est;
`ifdef NR_DIVIDER_EXACT_EN
               state_d = S_REM;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef NR_DIVIDER_EXACT_EN
         S_REM: begin
            r_d     = r_calc;
            state_d = in_range(r_calc, den_s) ? S_DONE : S_CORR;
         end
         S_CORR: begin
            q_d = r_q[RW-1] ? (q_q - WIDTH'(1)) : (q_q + WIDTH'(1));
            r_d = r_adj;
            if (in_range(r_adj, den_s)) state_d = S_DONE;
         end
`endif
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_q <= '0;
         den_q <= '0;
         q_q   <= '0;
         dn_q  <= '0;
         s_q   <= '0;
         x_q   <= '0;
         t_q   <= '0;
         ph_q  <= 1'b0;
         dz_q  <= 1'b0;
         it_q  <= '0;
`ifdef NR_DIVIDER_EXACT_EN
         r_q   <= '0;
`endif
      end else begin
         num_q <= num_d;
         den_q <= den_d;
         q_q   <= q_d;
         dn_q  <= dn_d;
         s_q   <= s_d;
         x_q   <= x_d;
         t_q   <= t_d;
         ph_q  <= ph_d;
         dz_q  <= dz_d;
         it_q  <= it_d;
`ifdef NR_DIVIDER_EXACT_EN
         r_q   <= r_d;
`endif
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign quotient    = q_q;
   assign div_by_zero = dz_q;
`ifdef NR_DIVIDER_EXACT_EN
   assign remainder   = r_q[WIDTH-1:0];
`else
   assign remainder   = '0;
`endif

endmodule

// File: tb/tb_nr_divider_pipe.sv
// Self-checking bench for nr_divider_pipe: directed corner cases, back-pressure, mid-operation
// reset and a random sweep, scored against plain integer division.
module tb_nr_divider_pipe;

   localparam int WIDTH = 16;
   localparam int ITERS = 3;
   localparam int ALL1  = (1 << WIDTH) - 1;
`ifdef NR_DIVIDER_EXACT_EN
   localparam int LAT_MIN = 3 + 2 * ITERS;
   localparam int LAT_MAX = 3 + 2 * ITERS + 2;
`else
   localparam int LAT_MIN = 2 + 2 * ITERS;
   localparam int LAT_MAX = 2 + 2 * ITERS;
`endif
   localparam int LAT_DZ = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] numerator;
   logic [WIDTH-1:0] denominator;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   typedef struct {
      int num;
      int den;
   } op_t;

   op_t              sb[$];
   int               checks = 0;
   int               errors = 0;
   logic             in_flight = 1'b0;
   logic             held = 1'b0;
   logic [WIDTH-1:0] prev_q, prev_r;
   logic             prev_dz;
   int               rn, rd, rbp;

   nr_divider_pipe #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .numerator   (numerator),
      .denominator (denominator),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic int gold_q(input int n, input int d);
      return (d == 0) ? ALL1 : n / d;
   endfunction

   function automatic int gold_r(input int n, input int d);
      return (d == 0) ? n : n % d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_rng(input string name, input logic [31:0] act, input int lo, input int hi);
      checks++;
      if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d..%0d (t=%0t)", name, act, lo, hi, $time);
      end
   endtask

   task automatic check_result(input int n, input int d);
`ifdef NR_DIVIDER_EXACT_EN
      chk("quotient", quotient, gold_q(n, d));
      chk("remainder", remainder, gold_r(n, d));
`else
      if (d == 0) chk("quotient", quotient, ALL1);
      else        chk_rng("quotient", quotient, gold_q(n, d) - 1, gold_q(n, d));
      chk("remainder", remainder, 0);
`endif
      chk("div_by_zero", div_by_zero, (d == 0));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_quotient"}, quotient, 0);
      chk({tag, "_remainder"}, remainder, 0);
      chk({tag, "_div_by_zero"}, div_by_zero, 0);
   endtask

   task automatic recover();
      rst_n = 1'b0;
      sb.delete();
      in_flight = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // lit_q < 0: no literal expectation; lat_fix <= 0: latency checked against its legal range
   task automatic run_op(input int n, input int d, input int bp,
                         input int lit_q, input int lit_r, input int lat_fix);
      int edges;
      @(negedge clk);
      in_valid    = 1'b1;
      numerator   = WIDTH'(n);
      denominator = WIDTH'(d);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_flight = 1'b1;
      sb.push_back('{num: n, den: d});
      edges = 0;
      while (!out_valid && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
      if (!out_valid) begin
         checks++;
         errors++;
         $display("FAIL timeout: no result for %0d/%0d after %0d edges", n, d, edges);
         recover();
         return;
      end
      if (d == 0)           chk("latency_dz", edges, LAT_DZ);
      else if (lat_fix > 0) chk("latency", edges, lat_fix);
      else                  chk_rng("latency", edges, LAT_MIN, LAT_MAX);
      if (lit_q >= 0) begin
`ifdef NR_DIVIDER_EXACT_EN
         chk("lit_quotient", quotient, lit_q);
         chk("lit_remainder", remainder, lit_r);
`else
         if (d == 0) chk("lit_quotient", quotient, lit_q);
         else        chk_rng("lit_quotient", quotient, lit_q - 1, lit_q);
         chk("lit_remainder", remainder, 0);
`endif
      end
      repeat (bp) begin
         @(posedge clk);
         #1;
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_flight = 1'b0;
      chk("handoff_in_ready", in_ready, 1);
      chk("handoff_out_valid", out_valid, 0);
   endtask

   // Per-cycle compare against the scoreboard, including hold stability under back-pressure
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", in_ready, !in_flight);
         if (out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL stale_result: out_valid high with nothing outstanding, q=%0d (t=%0t)",
                        quotient, $time);
            end else begin
               check_result(sb[0].num, sb[0].den);
               if (held) begin
                  chk("hold_quotient", quotient, prev_q);
                  chk("hold_remainder", remainder, prev_r);
                  chk("hold_div_by_zero", div_by_zero, prev_dz);
               end
               if (out_ready) begin
                  void'(sb.pop_front());
                  held = 1'b0;
               end else begin
                  held    = 1'b1;
                  prev_q  = quotient;
                  prev_r  = remainder;
                  prev_dz = div_by_zero;
               end
            end
         end else begin
            held = 1'b0;
         end
      end else begin
         held = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      numerator   = '0;
      denominator = '0;
      #2;
      check_reset_values("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      run_op(1000, 7, 0, 142, 6, LAT_MIN);
      run_op(65535, 1, 0, 65535, 0, -1);
      run_op(3, 65535, 0, 0, 3, -1);
      run_op(65535, 65535, 0, 1, 0, -1);
      run_op(32768, 3, 0, 10922, 2, -1);
      run_op(5, 0, 0, 65535, 5, -1);
      run_op(0, 0, 0, 65535, 0, -1);
      run_op(1000, 7, 5, 142, 6, LAT_MIN);
      run_op(0, 1, 0, 0, 0, -1);
      run_op(65534, 65535, 0, 0, 65534, -1);

      // abort 1000/7 while it is refining the reciprocal
      @(negedge clk);
      in_valid    = 1'b1;
      numerator   = WIDTH'(1000);
      denominator = WIDTH'(7);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_flight = 1'b1;
      sb.push_back('{num: 1000, den: 7});
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_reset_values("midreset");
      sb.delete();
      in_flight = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_op(200, 9, 0, 22, 2, -1);

      for (int i = 0; i < 2000; i++) begin
         rn  = int'($urandom_range(0, ALL1) >> $urandom_range(0, 15));
         rd  = int'($urandom_range(0, ALL1) >> $urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) rn = ALL1;
         if ($urandom_range(0, 31) == 0) rd = 0;
         rbp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_op(rn, rd, rbp, -1, -1, -1);
      end

      repeat (3) @(posedge clk);
      chk("final_queue_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
